branch_redirect: RTL
====================

BRANCH_REDIRECT -- requirements
Module: branch_redirect

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles flush stays asserted after redirect acceptance; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  control-transfer instruction present in EX this cycle.
REQ-005 ex_token  in  1  taken indication from branch unit (already 0 when branch unit disabled).
REQ-006 ex_is_jump  in  1  instruction is JAL or JALR (writes link register).
REQ-007 ex_is_jalr  in  1  target base is ex_op1, not ex_pc.
REQ-008 ex_pc  in  32  PC of EX instruction.
REQ-009 ex_op1  in  32  rs1 value (JALR base).
REQ-010 ex_imm  in  32  sign-extended immediate offset.
REQ-011 ex_ready  out  1  block accepts EX instruction this cycle.
REQ-012 redir_valid  out  1  redirect request to fetch.
REQ-013 redir_target  out  32  redirect PC, stable while redir_valid.
REQ-014 redir_ready  in  1  fetch accepts redirect.
REQ-015 flush  out  1  kill all instructions younger than the redirecting one.
REQ-016 link_valid  out  1  one-cycle pulse: link_data valid for writeback.
REQ-017 link_data  out  32  return address ex_pc+4.
REQ-018 misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned.

Function
REQ-019 Accept = ex_valid && ex_ready; ex_ready = 1 only in state IDLE.
REQ-020 Target: JALR -> (ex_op1+ex_imm) & ~32'h1; else ex_pc+ex_imm; all sums modulo 2^32 (wrap, no overflow flag).
REQ-021 Link value ex_pc+4 modulo 2^32 (pc 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 States: IDLE, REDIRECT, FLUSH; 4-bit down-counter cnt.
REQ-023 IDLE, accept, ex_token=1, target[1]=0: latch target into redir_target, next state REDIRECT.
REQ-024 IDLE, accept, ex_token=1, target[1]=1: no redirect, misalign_exc=1 next cycle only, stay IDLE, no link pulse.
REQ-025 IDLE, accept, ex_token=0: stay IDLE, no outputs change beyond link rule.
REQ-026 link_valid=1 in the cycle after any accept with ex_is_jump=1 and no misalignment; link_data registered at accept.
REQ-027 REDIRECT: redir_valid=1, flush=1; redir_target held; on redir_ready=1 -> FLUSH with cnt=FLUSH_CYCLES-1.
REQ-028 REDIRECT with redir_ready=0: hold indefinitely, no timeout.
REQ-029 FLUSH: redir_valid=0, flush=1; cnt=0 -> IDLE, else cnt decrements.
REQ-030 Total flush assertion = stall cycles in REDIRECT + 1 + FLUSH_CYCLES... precisely: cycles in REDIRECT plus FLUSH_CYCLES cycles in FLUSH.
REQ-031 ex_valid while not IDLE ignored (ex_ready=0); upstream holds instruction.
REQ-032 redir_ready outside REDIRECT ignored.
REQ-033 redir_valid never deasserts before handshake; redir_target never changes while redir_valid=1.

Reset
REQ-034 rst=1 asynchronously forces IDLE, cnt=0, redir_valid=0, redir_target=0, flush=0, link_valid=0, link_data=0, misalign_exc=0.
REQ-035 rst mid-REDIRECT or mid-FLUSH abandons request immediately; first cycle after rst release is IDLE with ex_ready=1.

Verification
REQ-036 BEQ taken, pc=0x100, imm=0x20, redir_ready=1 -> next cycle redir_valid=1, target 0x120; flush high 1+2 cycles; link_valid stays 0.
REQ-037 JALR, op1=0x1003, imm=0x4, redir_ready held 0 for 3 cycles -> target 0x1006, misalign_exc pulse, no redirect; repeat with op1=0x1000 -> target 0x1004, redir_valid held 3 cycles, link_data=pc+4.
REQ-038 JAL, pc=0xFFFF_FFFC, imm=0x8 -> target 0x0000_0004, link_data 0x0000_0000.
REQ-039 Not-taken BNE -> no redir_valid, no flush, ex_ready stays 1 next cycle.
REQ-040 Taken branch, then second ex_valid during FLUSH -> ex_ready=0, second ignored until IDLE.
REQ-041 rst asserted while in REDIRECT -> redir_valid and flush drop same cycle (async), IDLE after release.

Source files
------------

// File: rtl/branch_redirect_if.sv
// ============================================================================
// branch_redirect_if
// EX-stage control-transfer bus and fetch redirect/flush/link/exception bus.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_redirect_if;
   logic        ex_valid;
   logic        ex_token;
   logic        ex_is_jump;
   logic        ex_is_jalr;
   logic [31:0] ex_pc;
   logic [31:0] ex_op1;
   logic [31:0] ex_imm;
   logic        ex_ready;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        redir_ready;
   logic        flush;
   logic        link_valid;
   logic [31:0] link_data;
   logic        misalign_exc;

   modport slave (
      input  ex_valid, ex_token, ex_is_jump, ex_is_jalr, ex_pc, ex_op1, ex_imm, redir_ready,
      output ex_ready, redir_valid, redir_target, flush, link_valid, link_data, misalign_exc
   );

   modport master (
      output ex_valid, ex_token, ex_is_jump, ex_is_jalr, ex_pc, ex_op1, ex_imm, redir_ready,
      input  ex_ready, redir_valid, redir_target, flush, link_valid, link_data, misalign_exc
   );
endinterface

`default_nettype wire

// File: rtl/branch_redirect.sv
// ============================================================================
// branch_redirect
// Resolves taken control transfers in EX into a fetch redirect plus pipeline flush.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   branch_redirect_if.slave  bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_REDIRECT = 2'd1;
   localparam logic [1:0] ST_FLUSH    = 2'd2;
   localparam logic [3:0] CNT_LOAD    = 4'(FLUSH_CYCLES - 1);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic [31:0] base;
   logic [31:0] sum;
   logic [31:0] target;
   logic [31:0] link_addr;
   logic        accept;
   logic        misaligned;
   logic        take_redirect;
   logic [31:0] target_q;
   logic        link_valid_q;
   logic [31:0] link_data_q;
   logic        misalign_q;

   // JALR clears bit 0 of the sum; only bit 1 decides misalignment
   always_comb begin
      base          = bus.ex_is_jalr ? bus.ex_op1 : bus.ex_pc;
      sum           = base + bus.ex_imm;
      target        = {sum[31:1], sum[0] & ~bus.ex_is_jalr};
      link_addr     = bus.ex_pc + 32'd4;
      accept        = bus.ex_valid && (state == ST_IDLE);
      misaligned    = accept && bus.ex_token && target[1];
      take_redirect = accept && bus.ex_token && !target[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         target_q     <= 32'd0;
         link_valid_q <= 1'b0;
         link_data_q  <= 32'd0;
         misalign_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         link_valid_q <= accept && bus.ex_is_jump && !misaligned;
         misalign_q   <= misaligned;
         if (take_redirect) begin
            target_q <= target;
         end
         if (accept) begin
            link_data_q <= link_addr;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (take_redirect) begin
               state_nxt = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            if (bus.redir_ready) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = CNT_LOAD;
            end
         end
         ST_FLUSH: begin
            if (cnt == 4'd0) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Decoded straight from state so an asynchronous reset drops them at once
   always_comb begin
      bus.ex_ready     = (state == ST_IDLE);
      bus.redir_valid  = (state == ST_REDIRECT);
      bus.flush        = (state == ST_REDIRECT) || (state == ST_FLUSH);
      bus.redir_target = target_q;
      bus.link_valid   = link_valid_q;
      bus.link_data    = link_data_q;
      bus.misalign_exc = misalign_q;
   end

endmodule

`default_nettype wire
